// File: rtl/my_pwm_capture.sv
// -----------------------------------------------------------------------------
// my_pwm_capture
// Avalon-MM slave that measures an external PWM signal. It reports the period
// and the high time in clk cycles, packed like the PWM generator's control
// word. It also provides status flags and a level interrupt.
//
// Ports:
//   clk               system clock
//   reset             synchronous active-low reset
//   slave_address     register word address (0 CTRL, 1 STATUS, 2 MEAS)
//   slave_read        read strobe; a MEAS read consumes STATUS.valid
//   slave_write       write strobe
//   slave_readdata    read data, combinational from address
//   slave_writedata   write data
//   slave_byteenable  byte enables; only byte 0 gates CTRL writes
//   pwm_in            asynchronous PWM input
//   irq               STATUS.valid & CTRL.irq_en
//   led               synchronized pwm_in level
// -----------------------------------------------------------------------------
module my_pwm_capture #(
   parameter int CNT_W       = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  slave_address,
   input  logic        slave_read,
   input  logic        slave_write,
   output logic [31:0] slave_readdata,
   input  logic [31:0] slave_writedata,
   input  logic [3:0]  slave_byteenable,
   input  logic        pwm_in,
   output logic        irq,
   output logic        led
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ARM  = 2'd1,
      ST_MEAS = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

   // Input synchronizer and edge detection
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;
   logic                   sync_s;
   logic                   rise_s;
   logic                   fall_s;

   // Measurement FSM state
   state_t           state_q, state_d;
   logic [CNT_W-1:0] per_cnt_q, per_cnt_d;
   logic [CNT_W-1:0] hi_cnt_q, hi_cnt_d;
   logic [CNT_W-1:0] hi_lat_q, hi_lat_d;
   logic             hi_done_q, hi_done_d;
   logic [CNT_W-1:0] meas_per_q, meas_per_d;
   logic [CNT_W-1:0] meas_hi_q, meas_hi_d;
   logic             set_valid_s;
   logic             set_missed_s;
   logic             set_timeout_s;

   // Register file state
   logic [1:0] ctrl_q, ctrl_d;
   logic       valid_q, valid_d;
   logic       timeout_q, timeout_d;
   logic       missed_q, missed_d;
   logic       irq_q, irq_d;

   logic       wr_ctrl_s;
   logic       wr_status_s;
   logic       rd_meas_s;
   logic       unused_ok_s;

   assign sync_s = sync_q[SYNC_STAGES-1];
   assign rise_s = sync_s & ~prev_q;
   assign fall_s = ~sync_s & prev_q;

   assign wr_ctrl_s   = slave_write & (slave_address == 5'd0) & slave_byteenable[0];
   assign wr_status_s = slave_write & (slave_address == 5'd1);
   assign rd_meas_s   = slave_read  & (slave_address == 5'd2);

   assign unused_ok_s = ^{slave_writedata[31:3], slave_byteenable[3:1]};

   assign irq = irq_q;
   assign led = sync_s;

   // Measurement FSM: next state, counters and result latch
   always_comb begin
      state_d       = state_q;
      per_cnt_d     = per_cnt_q;
      hi_cnt_d      = hi_cnt_q;
      hi_lat_d      = hi_lat_q;
      hi_done_d     = hi_done_q;
      meas_per_d    = meas_per_q;
      meas_hi_d     = meas_hi_q;
      set_valid_s   = 1'b0;
      set_missed_s  = 1'b0;
      set_timeout_s = 1'b0;

      if (!ctrl_q[0]) begin
         // Disabled: abandon any partial measurement
         state_d   = ST_IDLE;
         per_cnt_d = CNT_ZERO;
         hi_cnt_d  = CNT_ZERO;
         hi_done_d = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               state_d   = ST_ARM;
               per_cnt_d = CNT_ZERO;
               hi_cnt_d  = CNT_ZERO;
               hi_done_d = 1'b0;
            end
            ST_ARM: begin
               if (rise_s) begin
                  state_d   = ST_MEAS;
                  per_cnt_d = CNT_ONE;
                  hi_cnt_d  = CNT_ONE;
                  hi_done_d = 1'b0;
               end else begin
                  state_d = ST_ARM;
               end
            end
            ST_MEAS: begin
               if (per_cnt_q == CNT_MAX) begin
                  // Period counter saturated: drop the partial result and re-arm
                  set_timeout_s = 1'b1;
                  state_d       = ST_ARM;
                  per_cnt_d     = CNT_ZERO;
                  hi_cnt_d      = CNT_ZERO;
                  hi_done_d     = 1'b0;
               end else if (rise_s) begin
                  // The rise both closes this period and opens the next one
                  meas_per_d   = per_cnt_q;
                  meas_hi_d    = hi_lat_q;
                  set_valid_s  = 1'b1;
                  set_missed_s = valid_q;
                  per_cnt_d    = CNT_ONE;
                  hi_cnt_d     = CNT_ONE;
                  hi_done_d    = 1'b0;
               end else begin
                  per_cnt_d = per_cnt_q + CNT_ONE;
                  if (sync_s && !hi_done_q && (hi_cnt_q != CNT_MAX)) begin
                     hi_cnt_d = hi_cnt_q + CNT_ONE;
                  end else begin
                     hi_cnt_d = hi_cnt_q;
                  end
                  if (fall_s) begin
                     hi_lat_d  = hi_cnt_q;
                     hi_done_d = 1'b1;
                  end else begin
                     hi_done_d = hi_done_q;
                  end
               end
            end
            default: begin
               state_d   = ST_IDLE;
               per_cnt_d = CNT_ZERO;
               hi_cnt_d  = CNT_ZERO;
               hi_done_d = 1'b0;
            end
         endcase
      end
   end

   // Register file: CTRL write, W1C status with hardware set taking priority
   always_comb begin
      ctrl_d    = ctrl_q;
      valid_d   = valid_q;
      timeout_d = timeout_q;
      missed_d  = missed_q;

      if (wr_ctrl_s) begin
         ctrl_d = slave_writedata[1:0];
      end else begin
         ctrl_d = ctrl_q;
      end

      if (wr_status_s) begin
         valid_d   = valid_q   & ~slave_writedata[0];
         timeout_d = timeout_q & ~slave_writedata[1];
         missed_d  = missed_q  & ~slave_writedata[2];
      end else begin
         valid_d   = valid_q;
         timeout_d = timeout_q;
         missed_d  = missed_q;
      end

      if (rd_meas_s) begin
         valid_d = 1'b0;
      end else begin
         valid_d = valid_d;
      end

      if (set_valid_s) begin
         valid_d = 1'b1;
      end else begin
         valid_d = valid_d;
      end

      if (set_missed_s) begin
         missed_d = 1'b1;
      end else begin
         missed_d = missed_d;
      end

      if (set_timeout_s) begin
         timeout_d = 1'b1;
      end else begin
         timeout_d = timeout_d;
      end

      // irq is registered from next-state values, so it tracks valid & irq_en exactly
      irq_d = valid_d & ctrl_d[1];
   end

   // Read mux, zero wait states
   always_comb begin
      slave_readdata = 32'h0000_0000;
      case (slave_address)
         5'd0:    slave_readdata = {30'd0, ctrl_q};
         5'd1:    slave_readdata = {28'd0, sync_s, missed_q, timeout_q, valid_q};
         5'd2:    slave_readdata = {meas_hi_q[15:0], meas_per_q[15:0]};
         default: slave_readdata = 32'h0000_0000;
      endcase
   end

   // All state flops with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!reset) begin
         sync_q     <= {SYNC_STAGES{1'b0}};
         prev_q     <= 1'b0;
         state_q    <= ST_IDLE;
         per_cnt_q  <= CNT_ZERO;
         hi_cnt_q   <= CNT_ZERO;
         hi_lat_q   <= CNT_ZERO;
         hi_done_q  <= 1'b0;
         meas_per_q <= CNT_ZERO;
         meas_hi_q  <= CNT_ZERO;
         ctrl_q     <= 2'b00;
         valid_q    <= 1'b0;
         timeout_q  <= 1'b0;
         missed_q   <= 1'b0;
         irq_q      <= 1'b0;
      end else begin
         sync_q     <= {sync_q[SYNC_STAGES-2:0], pwm_in};
         prev_q     <= sync_s;
         state_q    <= state_d;
         per_cnt_q  <= per_cnt_d;
         hi_cnt_q   <= hi_cnt_d;
         hi_lat_q   <= hi_lat_d;
         hi_done_q  <= hi_done_d;
         meas_per_q <= meas_per_d;
         meas_hi_q  <= meas_hi_d;
         ctrl_q     <= ctrl_d;
         valid_q    <= valid_d;
         timeout_q  <= timeout_d;
         missed_q   <= missed_d;
         irq_q      <= irq_d;
      end
   end

endmodule

// File: tb/tb_my_pwm_capture.sv
// -----------------------------------------------------------------------------
// Self-checking bench for my_pwm_capture. The bench generates the PWM waveforms
// itself, so each expected result follows from the period and high time it drove.
// -----------------------------------------------------------------------------
module tb_my_pwm_capture;

   logic        clk = 1'b0;
   logic        reset;
   logic [4:0]  slave_address;
   logic        slave_read;
   logic        slave_write;
   logic [31:0] slave_readdata;
   logic [31:0] slave_writedata;
   logic [3:0]  slave_byteenable;
   logic        pwm_in;
   logic        irq;
   logic        led;

   int passed = 0;
   int total  = 0;
   logic [31:0] exp_meas;

   always #5 clk = ~clk;

   my_pwm_capture #(.CNT_W(16), .SYNC_STAGES(2)) dut (
      .clk              (clk),
      .reset            (reset),
      .slave_address    (slave_address),
      .slave_read       (slave_read),
      .slave_write      (slave_write),
      .slave_readdata   (slave_readdata),
      .slave_writedata  (slave_writedata),
      .slave_byteenable (slave_byteenable),
      .pwm_in           (pwm_in),
      .irq              (irq),
      .led              (led)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic peek(input logic [4:0] a, output logic [31:0] d);
      slave_address = a;
      slave_read    = 1'b0;
      #1;
      d = slave_readdata;
   endtask

   task automatic bus_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
      slave_address    = a;
      slave_writedata  = d;
      slave_byteenable = be;
      slave_write      = 1'b1;
      tick();
      slave_write      = 1'b0;
   endtask

   task automatic bus_read(input logic [4:0] a, output logic [31:0] d);
      slave_address = a;
      slave_read    = 1'b1;
      #1;
      d = slave_readdata;
      tick();
      slave_read = 1'b0;
   endtask

   // Drive `count` PWM periods of n cycles with h high cycles, starting high
   task automatic run_pwm(input int n, input int h, input int count);
      for (int k = 0; k < count; k++) begin
         pwm_in = 1'b1;
         repeat (h) tick();
         pwm_in = 1'b0;
         repeat (n - h) tick();
      end
   endtask

   // Disable, clear status, re-enable with pwm_in held low
   task automatic restart(input logic [1:0] ctrl);
      pwm_in = 1'b0;
      bus_write(5'd0, 32'd0, 4'hF);
      repeat (3) tick();
      bus_write(5'd1, 32'd7, 4'hF);
      bus_write(5'd0, {30'd0, ctrl}, 4'hF);
      repeat (4) tick();
   endtask

   task automatic test_reset();
      logic [31:0] d;
      reset = 1'b0;
      pwm_in = 1'b0;
      repeat (3) tick();
      reset = 1'b1;
      tick();
      peek(5'd0, d); total++;
      if (d !== 32'd0) $display("FAIL reset_ctrl got=%h exp=%h", d, 32'd0); else passed++;
      peek(5'd1, d); total++;
      if (d !== 32'd0) $display("FAIL reset_status got=%h exp=%h", d, 32'd0); else passed++;
      peek(5'd2, d); total++;
      if (d !== 32'd0) $display("FAIL reset_meas got=%h exp=%h", d, 32'd0); else passed++;
      peek(5'd5, d); total++;
      if (d !== 32'd0) $display("FAIL reset_unmapped got=%h exp=%h", d, 32'd0); else passed++;
      total++;
      if (irq !== 1'b0) $display("FAIL reset_irq got=%b exp=0", irq); else passed++;
      total++;
      if (led !== 1'b0) $display("FAIL reset_led got=%b exp=0", led); else passed++;
   endtask

   task automatic test_basic();
      logic [31:0] d;
      restart(2'b01);
      bus_write(5'd0, 32'd0, 4'b1110);
      peek(5'd0, d); total++;
      if (d !== 32'd1) $display("FAIL ctrl_byteenable got=%h exp=%h", d, 32'd1); else passed++;
      run_pwm(100, 25, 1);
      // Second rise: result appears on the 3rd edge after pwm_in goes high
      pwm_in = 1'b1;
      tick();
      tick();
      peek(5'd1, d); total++;
      if (d[0] !== 1'b0) $display("FAIL latency_early got=%b exp=0", d[0]); else passed++;
      tick();
      peek(5'd1, d); total++;
      if (d[0] !== 1'b1) $display("FAIL latency_valid got=%b exp=1", d[0]); else passed++;
      exp_meas = {16'd25, 16'd100};
      repeat (22) tick();
      pwm_in = 1'b0;
      repeat (10) tick();
      bus_read(5'd2, d); total++;
      if (d !== exp_meas) $display("FAIL basic_meas got=%h exp=%h", d, exp_meas); else passed++;
      peek(5'd1, d); total++;
      if (d[0] !== 1'b0) $display("FAIL read_clears_valid got=%b exp=0", d[0]); else passed++;
   endtask

   task automatic test_irq_missed();
      logic [31:0] d;
      restart(2'b11);
      run_pwm(100, 25, 2);
      total++;
      if (irq !== 1'b1) $display("FAIL irq_set got=%b exp=1", irq); else passed++;
      bus_write(5'd1, 32'd1, 4'hF);
      total++;
      if (irq !== 1'b0) $display("FAIL irq_w1c got=%b exp=0", irq); else passed++;
      run_pwm(100, 25, 3);
      peek(5'd1, d); total++;
      if (d[2:0] !== 3'b101) $display("FAIL missed_status got=%b exp=%b", d[2:0], 3'b101); else passed++;
      peek(5'd2, d); total++;
      if (d !== exp_meas) $display("FAIL missed_meas got=%h exp=%h", d, exp_meas); else passed++;
      total++;
      if (irq !== 1'b1) $display("FAIL irq_again got=%b exp=1", irq); else passed++;
   endtask

   task automatic test_duty_edges();
      logic [31:0] d;
      int hs [2];
      hs[0] = 1;
      hs[1] = 9;
      for (int i = 0; i < 2; i++) begin
         restart(2'b01);
         run_pwm(10, hs[i], 3);
         exp_meas = {hs[i][15:0], 16'd10};
         peek(5'd2, d); total++;
         if (d !== exp_meas) $display("FAIL duty_meas h=%0d got=%h exp=%h", hs[i], d, exp_meas); else passed++;
         peek(5'd1, d); total++;
         if (d[0] !== 1'b1) $display("FAIL duty_valid h=%0d got=%b exp=1", hs[i], d[0]); else passed++;
      end
   endtask

   task automatic test_random();
      logic [31:0] d;
      int ns [$];
      int hs [$];
      int count;
      logic [2:0] exp_st;
      for (int t = 0; t < 4; t++) begin
         ns.delete();
         hs.delete();
         count = int'($urandom_range(2, 5));
         for (int k = 0; k < count; k++) begin
            ns.push_back(int'($urandom_range(2, 60)));
            hs.push_back(int'($urandom_range(1, ns[k] - 1)));
         end
         restart(2'b01);
         for (int k = 0; k < count; k++) run_pwm(ns[k], hs[k], 1);
         repeat (3) tick();
         // count rises yield count-1 results; the newest is the second-last period
         exp_meas = {hs[count-2][15:0], ns[count-2][15:0]};
         exp_st   = {(count - 1 >= 2), 1'b0, 1'b1};
         peek(5'd2, d); total++;
         if (d !== exp_meas) $display("FAIL rand_meas trial=%0d got=%h exp=%h", t, d, exp_meas); else passed++;
         peek(5'd1, d); total++;
         if (d[2:0] !== exp_st) $display("FAIL rand_status trial=%0d got=%b exp=%b", t, d[2:0], exp_st); else passed++;
      end
   endtask

   task automatic test_enable_clear();
      logic [31:0] d;
      restart(2'b01);
      run_pwm(20, 5, 2);
      exp_meas = {16'd5, 16'd20};
      peek(5'd2, d); total++;
      if (d !== exp_meas) $display("FAIL en_meas got=%h exp=%h", d, exp_meas); else passed++;
      bus_write(5'd0, 32'd0, 4'hF);
      bus_write(5'd1, 32'd1, 4'hF);
      run_pwm(20, 5, 1);
      peek(5'd1, d); total++;
      if (d[0] !== 1'b0) $display("FAIL en_off_valid got=%b exp=0", d[0]); else passed++;
      peek(5'd2, d); total++;
      if (d !== exp_meas) $display("FAIL en_off_meas got=%h exp=%h", d, exp_meas); else passed++;
      bus_write(5'd0, 32'd1, 4'hF);
      repeat (3) tick();
      run_pwm(30, 10, 1);
      peek(5'd1, d); total++;
      if (d[0] !== 1'b0) $display("FAIL en_one_rise got=%b exp=0", d[0]); else passed++;
      run_pwm(30, 10, 1);
      exp_meas = {16'd10, 16'd30};
      peek(5'd1, d); total++;
      if (d[0] !== 1'b1) $display("FAIL en_two_rise got=%b exp=1", d[0]); else passed++;
      peek(5'd2, d); total++;
      if (d !== exp_meas) $display("FAIL en_new_meas got=%h exp=%h", d, exp_meas); else passed++;
   endtask

   task automatic test_timeout();
      logic [31:0] d;
      int n_found;
      bus_write(5'd0, 32'd0, 4'hF);
      bus_write(5'd1, 32'd7, 4'hF);
      pwm_in = 1'b0;
      bus_write(5'd0, 32'd1, 4'hF);
      repeat (4) tick();
      pwm_in = 1'b1;
      n_found = -1;
      for (int n = 1; n <= 70000; n++) begin
         tick();
         peek(5'd1, d);
         if (d[1]) begin
            n_found = n;
            break;
         end
      end
      total++;
      if (n_found < 65536 || n_found > 65539)
         $display("FAIL timeout_cycles got=%0d exp=65536..65539", n_found);
      else passed++;
      peek(5'd1, d); total++;
      if (d !== 32'h0000_000A) $display("FAIL timeout_status got=%h exp=%h", d, 32'h0000_000A); else passed++;
      peek(5'd2, d); total++;
      if (d !== exp_meas) $display("FAIL timeout_meas got=%h exp=%h", d, exp_meas); else passed++;
      total++;
      if (led !== 1'b1) $display("FAIL timeout_led got=%b exp=1", led); else passed++;
      bus_write(5'd1, 32'd2, 4'hF);
      peek(5'd1, d); total++;
      if (d !== 32'h0000_0008) $display("FAIL timeout_w1c got=%h exp=%h", d, 32'h0000_0008); else passed++;
   endtask

   task automatic test_reset_mid();
      logic [31:0] d;
      restart(2'b11);
      run_pwm(40, 10, 2);
      pwm_in = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      tick();
      peek(5'd0, d); total++;
      if (d !== 32'd0) $display("FAIL rst_mid_ctrl got=%h exp=%h", d, 32'd0); else passed++;
      peek(5'd1, d); total++;
      if (d !== 32'd0) $display("FAIL rst_mid_status got=%h exp=%h", d, 32'd0); else passed++;
      peek(5'd2, d); total++;
      if (d !== 32'd0) $display("FAIL rst_mid_meas got=%h exp=%h", d, 32'd0); else passed++;
      total++;
      if (irq !== 1'b0) $display("FAIL rst_mid_irq got=%b exp=0", irq); else passed++;
      total++;
      if (led !== 1'b0) $display("FAIL rst_mid_led got=%b exp=0", led); else passed++;
      reset = 1'b1;
      pwm_in = 1'b0;
      tick();
   endtask

   initial begin
      reset            = 1'b0;
      slave_address    = 5'd0;
      slave_read       = 1'b0;
      slave_write      = 1'b0;
      slave_writedata  = 32'd0;
      slave_byteenable = 4'h0;
      pwm_in           = 1'b0;
      exp_meas         = 32'd0;
      test_reset();
      test_basic();
      test_irq_missed();
      test_duty_edges();
      test_random();
      test_enable_clear();
      test_timeout();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
